// File: rtl/mem_stage_pkg.sv
// Shared types for the vector memory stage: writeback source encoding,
// lane-sequencer states and a lane-counter width helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ALU = 2'b00,
    MEM = 2'b01,
    IMM = 2'b10
  } wr_src_t;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN
  } mem_state_t;

  // A single-lane vector still needs a 1-bit counter.
  function automatic int lane_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lane_seq.sv
// Lane sequencer: walks a vector load/store one lane per cycle over the
// single data-memory port and raises stall until the final cycle.
module mem_lane_seq
  import mem_stage_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic                                     is_store,
  input  logic                                     is_load,
  input  logic [registerSize-1:0]                  base,
  input  logic [vectorSize-1:0][registerSize-1:0]  operand,
  output logic                                     stall,
  output logic [addrWidth-1:0]                     mem_addr,
  output logic [registerSize-1:0]                  mem_wdata,
  output logic                                     mem_we,
  output logic                                     wb_load,
  output logic                                     cap_en,
  output logic [lane_bits(vectorSize)-1:0]         cap_lane
);

  localparam int LW = lane_bits(vectorSize);
  localparam logic [LW-1:0] LAST = LW'(vectorSize - 1);

  mem_state_t    state, state_next;
  logic [LW-1:0] lane, lane_next;
  logic          rd, fin, pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_next;
      lane  <= lane_next;
    end
  end

  // Everything is gated by rst so an abandoned operation issues nothing more.
  always_comb begin
    state_next = state;
    lane_next  = lane;
    mem_we     = 1'b0;
    rd         = 1'b0;
    cap_en     = 1'b0;
    cap_lane   = lane - LW'(1);
    fin        = 1'b0;
    pass       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_store) begin
            mem_we = 1'b1;
            if (vectorSize == 1) begin
              fin = 1'b1;
            end else begin
              state_next = STORE;
              lane_next  = LW'(1);
            end
          end else if (is_load) begin
            rd = 1'b1;
            if (vectorSize == 1) begin
              state_next = DRAIN;
            end else begin
              state_next = LOAD;
              lane_next  = LW'(1);
            end
          end else if (valid_in) begin
            pass = 1'b1;
          end
        end
        STORE: begin
          mem_we = 1'b1;
          if (lane == LAST) begin
            fin        = 1'b1;
            state_next = IDLE;
            lane_next  = '0;
          end else begin
            lane_next = lane + LW'(1);
          end
        end
        LOAD: begin
          rd     = 1'b1;
          cap_en = 1'b1;
          if (lane == LAST) begin
            state_next = DRAIN;
            lane_next  = '0;
          end else begin
            lane_next = lane + LW'(1);
          end
        end
        DRAIN: begin
          cap_en     = 1'b1;
          cap_lane   = LAST;
          fin        = 1'b1;
          state_next = IDLE;
          lane_next  = '0;
        end
        default: begin
          state_next = IDLE;
          lane_next  = '0;
        end
      endcase
    end
  end

  // Lane is held at 0 in IDLE, so the first access of an op uses the base.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we || rd) mem_addr = addrWidth'(base) + addrWidth'(lane);
    if (mem_we) mem_wdata = operand[lane];
  end

  assign stall   = (mem_we | rd) & ~fin;
  assign wb_load = fin | pass;

endmodule

// File: rtl/stage_memory.sv
// Vector memory stage top: load lane buffer, writeback source selection
// and the registered writeback interface to the register file.
module stage_memory
  import mem_stage_pkg::*;
#(
  parameter int registerSize = 8,
  parameter int vectorSize   = 4,
  parameter int addrWidth    = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     valid_in,
  input  logic                                     mem_write_in,
  input  logic [1:0]                               write_reg_from_in,
  input  logic [3:0]                               reg_to_write_in,
  input  logic                                     reg_wr_en_sc_in,
  input  logic                                     reg_wr_en_vec_in,
  input  logic [registerSize-1:0]                  immediate_in,
  input  logic [vectorSize-1:0][registerSize-1:0]  operand_in,
  output logic                                     stall,
  output logic [addrWidth-1:0]                     mem_addr,
  output logic [registerSize-1:0]                  mem_wdata,
  output logic                                     mem_we,
  input  logic [registerSize-1:0]                  mem_rdata,
  output logic                                     wb_valid,
  output logic [vectorSize-1:0][registerSize-1:0]  wb_data,
  output logic [3:0]                               wb_reg,
  output logic                                     wb_en_sc,
  output logic                                     wb_en_vec
);

  localparam int LW = lane_bits(vectorSize);

  logic          is_store, is_load;
  logic          wb_load, cap_en;
  logic [LW-1:0] cap_lane;

  logic [vectorSize-1:0][registerSize-1:0] load_buf, wb_next;
  logic                                    en_sc_next, en_vec_next;

  assign is_store = valid_in & mem_write_in;
  assign is_load  = valid_in & ~mem_write_in & (wr_src_t'(write_reg_from_in) == MEM);

  mem_lane_seq #(
    .registerSize(registerSize),
    .vectorSize  (vectorSize),
    .addrWidth   (addrWidth)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .is_store (is_store),
    .is_load  (is_load),
    .base     (immediate_in),
    .operand  (operand_in),
    .stall    (stall),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .wb_load  (wb_load),
    .cap_en   (cap_en),
    .cap_lane (cap_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      load_buf <= '0;
    end else if (cap_en) begin
      load_buf[cap_lane] <= mem_rdata;
    end
  end

  // The last load lane arrives during DRAIN, so it bypasses load_buf here.
  always_comb begin
    wb_next     = operand_in;
    en_sc_next  = reg_wr_en_sc_in;
    en_vec_next = reg_wr_en_vec_in;
    if (is_store) begin
      en_sc_next  = 1'b0;
      en_vec_next = 1'b0;
    end else if (is_load) begin
      wb_next                 = load_buf;
      wb_next[vectorSize-1]   = mem_rdata;
    end else if (wr_src_t'(write_reg_from_in) == IMM) begin
      wb_next    = '0;
      wb_next[0] = immediate_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_reg    <= '0;
      wb_en_sc  <= 1'b0;
      wb_en_vec <= 1'b0;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_data   <= wb_next;
        wb_reg    <= reg_to_write_in;
        wb_en_sc  <= en_sc_next;
        wb_en_vec <= en_vec_next;
      end else begin
        wb_reg    <= '0;
        wb_en_sc  <= 1'b0;
        wb_en_vec <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory (V=4, 8-bit lanes) with a synchronous
// byte memory model answering one cycle after the address.
module tb_stage_memory;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in, mem_write_in;
  logic [1:0]       write_reg_from_in;
  logic [3:0]       reg_to_write_in;
  logic             reg_wr_en_sc_in, reg_wr_en_vec_in;
  logic [7:0]       immediate_in;
  logic [3:0][7:0]  operand_in;
  logic             stall;
  logic [15:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             mem_we;
  logic [7:0]       mem_rdata;
  logic             wb_valid;
  logic [3:0][7:0]  wb_data;
  logic [3:0]       wb_reg;
  logic             wb_en_sc, wb_en_vec;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_memory #(
    .registerSize(8),
    .vectorSize  (4),
    .addrWidth   (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_write_in     (mem_write_in),
    .write_reg_from_in(write_reg_from_in),
    .reg_to_write_in  (reg_to_write_in),
    .reg_wr_en_sc_in  (reg_wr_en_sc_in),
    .reg_wr_en_vec_in (reg_wr_en_vec_in),
    .immediate_in     (immediate_in),
    .operand_in       (operand_in),
    .stall            (stall),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_rdata        (mem_rdata),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_reg           (wb_reg),
    .wb_en_sc         (wb_en_sc),
    .wb_en_vec        (wb_en_vec)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] src,
                       input logic [3:0] rd, input logic sc, input logic vec,
                       input logic [7:0] imm, input logic [31:0] op);
    valid_in          = v;
    mem_write_in      = we;
    write_reg_from_in = src;
    reg_to_write_in   = rd;
    reg_wr_en_sc_in   = sc;
    reg_wr_en_vec_in  = vec;
    immediate_in      = imm;
    operand_in        = op;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // Presents a store for cycles 0..3; returns just after the edge ending cycle 3.
  task automatic do_store(input logic [7:0] imm, input logic [31:0] op, input logic [1:0] src);
    logic [3:0][7:0] lanes;
    lanes = op;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, src, 4'd9, 1'b1, 1'b1, imm, op);
      check($sformatf("st_we[%0d]", c), mem_we, 1'b1);
      check($sformatf("st_addr[%0d]", c), mem_addr, 16'(imm) + 16'(c));
      check($sformatf("st_wdata[%0d]", c), mem_wdata, lanes[c]);
      check($sformatf("st_stall[%0d]", c), stall, (c < 3) ? 1'b1 : 1'b0);
      step();
    end
  endtask

  // Presents a load for cycles 0..4; returns just after the edge ending cycle 4.
  task automatic do_load(input logic [7:0] imm, input logic [3:0] rd);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 2'b01, rd, 1'b0, 1'b1, imm, 32'hDEADBEEF);
      check($sformatf("ld_stall[%0d]", c), stall, (c < 4) ? 1'b1 : 1'b0);
      check($sformatf("ld_we[%0d]", c), mem_we, 1'b0);
      if (c < 4) check($sformatf("ld_addr[%0d]", c), mem_addr, 16'(imm) + 16'(c));
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_stall", stall, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 8'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_ctl", {wb_reg, wb_en_sc, wb_en_vec}, 6'h0);
    rst = 1'b0;
    idle();
    step();

    // Pass-through ALU op
    drive(1'b1, 1'b0, 2'b00, 4'd5, 1'b0, 1'b1, 8'h99, 32'h04030201);
    check("pt_stall", stall, 1'b0);
    check("pt_we", mem_we, 1'b0);
    step();
    idle();
    check("pt_wb_valid", wb_valid, 1'b1);
    check("pt_wb_data", wb_data, 32'h04030201);
    check("pt_wb_reg", wb_reg, 4'd5);
    check("pt_wb_en", {wb_en_sc, wb_en_vec}, 2'b01);
    step();
    check("bubble_wb_valid", wb_valid, 1'b0);
    check("bubble_wb_reg", wb_reg, 4'd0);
    check("bubble_we", mem_we, 1'b0);

    // Store 0x10..0x13
    do_store(8'h10, 32'hDDCCBBAA, 2'b00);
    idle();
    check("st_wb_valid", wb_valid, 1'b1);
    check("st_wb_en", {wb_en_sc, wb_en_vec}, 2'b00);
    check("st_wb_data", wb_data, 32'hDDCCBBAA);
    check("st_we_after", mem_we, 1'b0);
    step();
    check("st_wb_valid_drop", wb_valid, 1'b0);

    // Load 0x20..0x23 back-to-back with a store to 0x30
    do_store(8'h20, 32'h04030201, 2'b00);
    idle();
    step();
    do_load(8'h20, 4'd7);
    drive(1'b1, 1'b1, 2'b00, 4'd9, 1'b1, 1'b1, 8'h30, 32'h88776655);
    check("ld_wb_valid", wb_valid, 1'b1);
    check("ld_wb_data", wb_data, 32'h04030201);
    check("ld_wb_reg", wb_reg, 4'd7);
    check("ld_wb_en", {wb_en_sc, wb_en_vec}, 2'b01);
    do_store(8'h30, 32'h88776655, 2'b00);
    idle();
    check("b2b_wb_valid", wb_valid, 1'b1);
    step();
    do_load(8'h30, 4'd2);
    idle();
    check("b2b_readback", wb_data, 32'h88776655);
    step();

    // Reset in the middle of a store
    do_store(8'h40, 32'h55555555, 2'b00);
    idle();
    step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 2'b00, 4'd9, 1'b1, 1'b1, 8'h40, 32'h44332211);
      check($sformatf("rs_we[%0d]", c), mem_we, 1'b1);
      step();
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 4'd9, 1'b1, 1'b1, 8'h40, 32'h44332211);
    check("rs_we_gated", mem_we, 1'b0);
    step();
    check("rs_stall", stall, 1'b0);
    check("rs_we_after", mem_we, 1'b0);
    check("rs_wb_valid", wb_valid, 1'b0);
    check("rs_wb_reg", wb_reg, 4'd0);
    rst = 1'b0;
    idle();
    step();
    check("rs_wb_valid2", wb_valid, 1'b0);
    do_load(8'h40, 4'd1);
    idle();
    check("rs_readback", wb_data, 32'h55552211);
    step();

    // Immediate source
    drive(1'b1, 1'b0, 2'b10, 4'd3, 1'b1, 1'b0, 8'h7F, 32'hFFFFFFFF);
    check("imm_stall", stall, 1'b0);
    step();
    idle();
    check("imm_wb_valid", wb_valid, 1'b1);
    check("imm_wb_data", wb_data, 32'h0000007F);
    check("imm_wb_ctl", {wb_reg, wb_en_sc, wb_en_vec}, {4'd3, 2'b10});
    step();

    // Source 11 behaves as ALU
    drive(1'b1, 1'b0, 2'b11, 4'd4, 1'b0, 1'b1, 8'h12, 32'hA1B2C3D4);
    check("src11_we", mem_we, 1'b0);
    step();
    idle();
    check("src11_wb_data", wb_data, 32'hA1B2C3D4);
    step();

    // Store flag wins over memory writeback source
    do_store(8'h50, 32'h0D0C0B0A, 2'b01);
    idle();
    check("conf_wb_valid", wb_valid, 1'b1);
    check("conf_wb_en", {wb_en_sc, wb_en_vec}, 2'b00);
    step();
    do_load(8'h50, 4'd6);
    idle();
    check("conf_readback", wb_data, 32'h0D0C0B0A);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
